// File: rtl/polar_encoder_stream.sv
// polar_encoder_stream: streaming NR polar encoder, serial u in, in-place butterflies, serial x out
module polar_encoder_stream #(
  parameter int NMAX_LOG2 = 10,
  parameter int NMIN_LOG2 = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enb,
  input  logic       in_bit,
  input  logic       in_start,
  input  logic       in_end,
  input  logic       in_valid,
  input  logic [3:0] in_log2n,
  output logic       in_ready,
  output logic       out_bit,
  output logic       out_start,
  output logic       out_end,
  output logic       out_valid,
  output logic       err
);
  localparam int D = 1 << NMAX_LOG2;
  localparam logic [NMAX_LOG2:0] ONE = (NMAX_LOG2 + 1)'(1);
  typedef enum logic [1:0] {IDLE, LOAD, ENC, OUT} state_t;
  state_t state;
  logic [D-1:0] mem, mem_enc;
  logic [3:0] n, stage;
  logic [NMAX_LOG2-1:0] idx;
  logic [NMAX_LOG2:0] len;
  logic ok, last;
  assign len = ONE << n;
  assign last = {1'b0, idx} == len - ONE;
  assign ok = in_log2n >= 4'(NMIN_LOG2) && in_log2n <= 4'(NMAX_LOG2);
  assign in_ready = state == IDLE || state == LOAD;
  for (genvar g = 0; g < D; g++) begin : g_bf
    logic [NMAX_LOG2-1:0] p;
    for (genvar s = 0; s < NMAX_LOG2; s++) begin : g_st
      if (((g >> s) & 1) != 0) begin : g_hi
        assign p[s] = 1'b0;
      end else begin : g_lo
        assign p[s] = mem[g | (1 << s)];
      end
    end
    assign mem_enc[g] = mem[g] ^ (p[stage] && len > (NMAX_LOG2 + 1)'(g));
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      n <= '0;
      stage <= '0;
      idx <= '0;
      out_bit <= 1'b0;
      out_start <= 1'b0;
      out_end <= 1'b0;
      out_valid <= 1'b0;
      err <= 1'b0;
    end else if (enb) begin
      err <= 1'b0;
      out_valid <= 1'b0;
      out_start <= 1'b0;
      out_end <= 1'b0;
      case (state)
        IDLE, LOAD: if (in_valid) begin
          if (in_start) begin
            if (!ok || in_end) begin
              err <= 1'b1;
              state <= IDLE;
            end else begin
              n <= in_log2n;
              mem[0] <= in_bit;
              idx <= ONE[NMAX_LOG2-1:0];
              state <= LOAD;
            end
          end else if (state == LOAD) begin
            mem[idx] <= in_bit;
            if (last && in_end) begin
              stage <= '0;
              state <= ENC;
            end else if (last || in_end) begin
              err <= 1'b1;
              state <= IDLE;
            end else idx <= idx + ONE[NMAX_LOG2-1:0];
          end
        end
        ENC: begin
          mem <= mem_enc;
          stage <= stage + 4'd1;
          if (stage == n - 4'd1) begin
            idx <= '0;
            state <= OUT;
          end
        end
        OUT: begin
          out_bit <= mem[idx];
          out_valid <= 1'b1;
          out_start <= idx == '0;
          out_end <= last;
          idx <= idx + ONE[NMAX_LOG2-1:0];
          if (last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
